// File: rtl/event_readout_framer_if.sv
// event_readout_framer_if: FIFO read, reset-handshake and framed output stream signals of the readout framer
interface event_readout_framer_if;
    logic fifo_empty;
    logic [15:0] dat;
    logic [1:0] word_type;
    logic fifo_rd;
    logic fifo_block_done;
    logic rst_req;
    logic rst_ack;
    logic [15:0] out_dat;
    logic out_last;
    logic out_valid;
    logic out_ready;
    logic [15:0] block_count;
    logic err;
    modport master (
        input fifo_empty, dat, word_type, rst_req, out_ready,
        output fifo_rd, fifo_block_done, rst_ack, out_dat, out_last, out_valid, block_count, err
    );
    modport slave (
        output fifo_empty, dat, word_type, rst_req, out_ready,
        input fifo_rd, fifo_block_done, rst_ack, out_dat, out_last, out_valid, block_count, err
    );
endinterface

// File: rtl/event_readout_framer.sv
// event_readout_framer: pops FWFT event FIFO words and re-emits them as framed valid/ready blocks
module event_readout_framer #(
    parameter int MAX_BLOCK_WORDS = 1024,
    parameter logic [15:0] FILL_WORD = 16'hDEAD
) (
    input logic clk_i,
    input logic rst_n_i,
    event_readout_framer_if.master bus
);
    localparam int CW = $clog2(MAX_BLOCK_WORDS + 1);
    typedef enum logic [2:0] {IDLE, STREAM, CLOSE, FLUSH, ACK} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [15:0] out_dat, dat_nx, block_count;
    logic out_valid, out_last, last_nx, err, set_err, load, pop, load_en, avail, accept;
    assign load_en = !out_valid || bus.out_ready;
    assign avail = load_en && !bus.fifo_empty;
    assign accept = out_valid && bus.out_ready;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        dat_nx = bus.dat;
        last_nx = 1'b0;
        load = 1'b0;
        pop = 1'b0;
        set_err = 1'b0;
        case (state)
            IDLE:
                if (bus.rst_req) state_nx = FLUSH;
                else if (avail) begin
                    pop = 1'b1;
                    load = bus.word_type[0];
                    last_nx = bus.word_type[1];
                    set_err = !bus.word_type[0] || (bus.word_type == 2'b01 && MAX_BLOCK_WORDS == 1);
                    if (bus.word_type == 2'b01) begin
                        cnt_nx = CW'(1);
                        state_nx = (MAX_BLOCK_WORDS == 1) ? CLOSE : STREAM;
                    end
                end
            STREAM:
                // a last word racing a reset request still completes its frame naturally
                if (avail && bus.word_type == 2'b10) begin
                    pop = 1'b1;
                    load = 1'b1;
                    last_nx = 1'b1;
                    state_nx = bus.rst_req ? FLUSH : IDLE;
                end else if (bus.rst_req || (!bus.fifo_empty && bus.word_type[0])) begin
                    set_err = !bus.rst_req;
                    state_nx = CLOSE;
                end else if (avail) begin
                    pop = 1'b1;
                    load = 1'b1;
                    cnt_nx = cnt + 1'b1;
                    if (cnt_nx == CW'(MAX_BLOCK_WORDS)) begin
                        set_err = 1'b1;
                        state_nx = CLOSE;
                    end
                end
            CLOSE:
                if (load_en) begin
                    load = 1'b1;
                    dat_nx = FILL_WORD;
                    last_nx = 1'b1;
                    state_nx = bus.rst_req ? FLUSH : IDLE;
                end
            FLUSH:
                if (!out_valid) begin
                    pop = !bus.fifo_empty;
                    state_nx = bus.fifo_empty ? ACK : FLUSH;
                end
            ACK: state_nx = bus.rst_req ? ACK : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_dat <= '0;
            block_count <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            err <= err || set_err;
            out_valid <= load || (out_valid && !bus.out_ready);
            if (load) begin
                out_dat <= dat_nx;
                out_last <= last_nx;
            end
            if (accept && out_last) block_count <= block_count + 16'd1;
        end
    end
    assign bus.fifo_rd = pop;
    assign bus.fifo_block_done = rst_n_i && accept && out_last;
    assign bus.rst_ack = state == ACK && bus.rst_req;
    assign bus.out_dat = out_dat;
    assign bus.out_last = out_last;
    assign bus.out_valid = out_valid;
    assign bus.block_count = block_count;
    assign bus.err = err;
endmodule
